// File: rtl/tx_port_scheduler_if.sv
// TX port arbitration bundle: requester queues on one side, the port scheduler on the other.
// The scheduler drives pops, grants and port status; the queues drive requests and end-of-frame flags.
interface tx_port_scheduler_if #(
    parameter int P_NUM_REQ = 3
);
    logic [P_NUM_REQ-1:0] req_i;
    logic [P_NUM_REQ-1:0] eof_i;
    logic [P_NUM_REQ-1:0] rd_en_o;
    logic [P_NUM_REQ-1:0] grant_o;
    logic                 tx_ctrl_o;
    logic                 busy_o;
    logic                 timeout_o;

    modport master (
        input  req_i, eof_i,
        output rd_en_o, grant_o, tx_ctrl_o, busy_o, timeout_o
    );

    modport slave (
        output req_i, eof_i,
        input  rd_en_o, grant_o, tx_ctrl_o, busy_o, timeout_o
    );
endinterface

// File: rtl/tx_port_scheduler.sv
// Round-robin owner of one TX port: grant 1 cycle after request, pops until eof or byte watchdog, then IFG.
// No backpressure from the port; requesters are held off by grant/rd_en, and tx_ctrl lags rd_en by one cycle.
module tx_port_scheduler #(
    parameter int P_NUM_REQ    = 3,
    parameter int P_IFG_CYCLES = 12,
    parameter int P_MAX_BYTES  = 1518
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    tx_port_scheduler_if.master   sched
);
    localparam int IDX_W = (P_NUM_REQ > 1) ? $clog2(P_NUM_REQ) : 1;
    localparam int CNT_W = $clog2(P_MAX_BYTES + 1);
    localparam int GAP_W = (P_IFG_CYCLES > 1) ? $clog2(P_IFG_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [P_NUM_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [CNT_W-1:0]     byte_cnt_q, byte_cnt_d;
    logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
    logic                 tx_ctrl_q;
    logic                 timeout_q, timeout_d;

    logic [P_NUM_REQ-1:0] req_rot;
    logic [P_NUM_REQ-1:0] sel_onehot;
    logic [IDX_W-1:0]     sel_idx;
    logic                 sel_vld;
    int                   sel_sum;

    logic [P_NUM_REQ-1:0] rd_en;
    logic                 eof_hit;
    logic                 last_pop;

    // Rotate so bit 0 is the requester just after the last winner; the first set bit wins.
    assign req_rot = P_NUM_REQ'({sched.req_i, sched.req_i} >> (int'(ptr_q) + 1));

    always_comb begin
        sel_vld    = 1'b0;
        sel_sum    = 0;
        sel_idx    = '0;
        sel_onehot = '0;
        for (int i = 0; i < P_NUM_REQ; i++) begin
            if (!sel_vld && req_rot[i]) begin
                sel_vld = 1'b1;
                sel_sum = int'(ptr_q) + 1 + i;
            end
        end
        if (sel_sum >= P_NUM_REQ) begin
            sel_sum = sel_sum - P_NUM_REQ;
        end
        sel_idx = IDX_W'(sel_sum);
        for (int j = 0; j < P_NUM_REQ; j++) begin
            sel_onehot[j] = sel_vld && (sel_idx == IDX_W'(j));
        end
    end

    assign rd_en    = (state_q == S_XFER) ? grant_q : '0;
    assign eof_hit  = |(sched.eof_i & rd_en);
    assign last_pop = (byte_cnt_q == CNT_W'(P_MAX_BYTES - 1));

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        byte_cnt_d = byte_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        timeout_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (sel_vld) begin
                    grant_d    = sel_onehot;
                    ptr_d      = sel_idx;
                    byte_cnt_d = '0;
                    state_d    = S_XFER;
                end
            end
            S_XFER: begin
                byte_cnt_d = byte_cnt_q + 1'b1;
                // A pop that is both the last allowed byte and eof is a clean end, not an abort.
                if (eof_hit || last_pop) begin
                    state_d   = S_GAP;
                    grant_d   = '0;
                    gap_cnt_d = GAP_W'(P_IFG_CYCLES - 1);
                    timeout_d = !eof_hit;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            ptr_q      <= IDX_W'(P_NUM_REQ - 1);
            byte_cnt_q <= '0;
            gap_cnt_q  <= '0;
            tx_ctrl_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ptr_q      <= ptr_d;
            byte_cnt_q <= byte_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            tx_ctrl_q  <= |rd_en;
            timeout_q  <= timeout_d;
        end
    end

    assign sched.rd_en_o   = rd_en;
    assign sched.grant_o   = grant_q;
    assign sched.tx_ctrl_o = tx_ctrl_q;
    assign sched.busy_o    = (state_q != S_IDLE);
    assign sched.timeout_o = timeout_q;

endmodule

// File: tb/tb_tx_port_scheduler.sv
// Directed bench for tx_port_scheduler: the bench plays the requester queues, raising eof on a per-queue frame length.
// Outputs are sampled on the falling edge; eof for the next rising edge is driven from that sample.
module tb_tx_port_scheduler;
    localparam int N = 3;

    logic clk_i = 1'b0;
    logic rst_i;
    always #5 clk_i = ~clk_i;

    tx_port_scheduler_if #(.P_NUM_REQ(N)) bus ();

    tx_port_scheduler #(
        .P_NUM_REQ   (N),
        .P_IFG_CYCLES(12),
        .P_MAX_BYTES (1518)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .sched(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    int           frame_len[N];
    int           pop_cnt[N];
    logic [N-1:0] eof_force;
    logic [N-1:0] s_grant, s_rd;
    logic         s_tx, s_busy, s_to;

    // One cycle: sample outputs, then drive eof for any queue whose frame ends on the pop just seen.
    task automatic step();
        logic [N-1:0] ev;
        @(negedge clk_i);
        s_grant = bus.grant_o;
        s_rd    = bus.rd_en_o;
        s_tx    = bus.tx_ctrl_o;
        s_busy  = bus.busy_o;
        s_to    = bus.timeout_o;
        ev = '0;
        for (int i = 0; i < N; i++) begin
            if (s_rd[i]) begin
                pop_cnt[i]++;
                if (frame_len[i] != 0 && pop_cnt[i] == frame_len[i]) begin
                    ev[i] = 1'b1;
                    pop_cnt[i] = 0;
                end
            end
        end
        bus.eof_i = ev | eof_force;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        bus.req_i = '0;
        eof_force = '0;
        for (int i = 0; i < N; i++) begin
            pop_cnt[i] = 0;
            frame_len[i] = 0;
        end
        step();
        step();
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        bus.req_i = 3'b111;
        bus.eof_i = '0;
        eof_force = '0;
        for (int i = 0; i < N; i++) begin
            pop_cnt[i] = 0;
            frame_len[i] = 0;
        end
        step(); step(); step();
        n_cmp++; if (s_grant !== 3'b000) begin n_bad++; $display("FAIL reset_grant: got %b want 000", s_grant); end
        n_cmp++; if (s_rd !== 3'b000) begin n_bad++; $display("FAIL reset_rd_en: got %b want 000", s_rd); end
        n_cmp++; if (s_tx !== 1'b0) begin n_bad++; $display("FAIL reset_tx_ctrl: got %b want 0", s_tx); end
        n_cmp++; if (s_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", s_busy); end
        n_cmp++; if (s_to !== 1'b0) begin n_bad++; $display("FAIL reset_timeout: got %b want 0", s_to); end
        // Index 0 must win first after reset even with everyone requesting.
        rst_i = 1'b0;
        frame_len[0] = 4;
        step();
        n_cmp++; if (s_grant !== 3'b001) begin n_bad++; $display("FAIL reset_first_winner: got %b want 001", s_grant); end
        bus.req_i = '0;
        for (int k = 0; k < 30; k++) step();
    endtask

    task automatic test_single_frame();
        int rd_c, tx_c, busy_c, to_c;
        do_reset();
        frame_len[1] = 64;
        bus.req_i = 3'b010;
        step();
        n_cmp++; if (s_grant !== 3'b010) begin n_bad++; $display("FAIL single_grant: got %b want 010", s_grant); end
        n_cmp++; if (s_rd !== 3'b010) begin n_bad++; $display("FAIL single_rd_en_first: got %b want 010", s_rd); end
        n_cmp++; if (s_tx !== 1'b0) begin n_bad++; $display("FAIL single_tx_early: got %b want 0", s_tx); end
        bus.req_i = '0;
        rd_c = int'(s_rd[1]);
        tx_c = int'(s_tx);
        busy_c = int'(s_busy);
        to_c = int'(s_to);
        for (int k = 0; k < 150; k++) begin
            step();
            if (k == 0) begin
                n_cmp++; if (s_tx !== 1'b1) begin n_bad++; $display("FAIL single_tx_lag: got %b want 1", s_tx); end
            end
            rd_c += int'(s_rd[1]);
            tx_c += int'(s_tx);
            busy_c += int'(s_busy);
            to_c += int'(s_to);
        end
        n_cmp++; if (rd_c != 64) begin n_bad++; $display("FAIL single_rd_cycles: got %0d want 64", rd_c); end
        n_cmp++; if (tx_c != 64) begin n_bad++; $display("FAIL single_tx_cycles: got %0d want 64", tx_c); end
        n_cmp++; if (busy_c != 76) begin n_bad++; $display("FAIL single_busy_cycles: got %0d want 76", busy_c); end
        n_cmp++; if (to_c != 0) begin n_bad++; $display("FAIL single_timeout: got %0d want 0", to_c); end
    endtask

    task automatic test_round_robin();
        int order[$];
        int gaps[$];
        int exp_o[5] = '{0, 1, 2, 0, 1};
        logic [N-1:0] prev_g;
        logic prev_tx, seen_rise;
        int low_run;
        do_reset();
        for (int i = 0; i < N; i++) frame_len[i] = 64;
        bus.req_i = 3'b111;
        prev_g = '0; prev_tx = 1'b0; seen_rise = 1'b0; low_run = 0;
        for (int k = 0; k < 600; k++) begin
            step();
            if (s_grant != '0 && prev_g == '0) begin
                for (int j = 0; j < N; j++) if (s_grant[j]) order.push_back(j);
                if (order.size() == 5) bus.req_i = '0;
            end
            prev_g = s_grant;
            if (s_tx && !prev_tx) begin
                if (seen_rise) gaps.push_back(low_run);
                seen_rise = 1'b1;
            end
            if (!s_tx) low_run++; else low_run = 0;
            prev_tx = s_tx;
        end
        n_cmp++; if (order.size() != 5) begin n_bad++; $display("FAIL rr_grant_count: got %0d want 5", order.size()); end
        for (int k = 0; k < 5; k++) begin
            if (k < order.size()) begin
                n_cmp++; if (order[k] != exp_o[k]) begin n_bad++; $display("FAIL rr_order[%0d]: got %0d want %0d", k, order[k], exp_o[k]); end
            end
        end
        n_cmp++; if (gaps.size() != 4) begin n_bad++; $display("FAIL rr_gap_count: got %0d want 4", gaps.size()); end
        foreach (gaps[k]) begin
            n_cmp++; if (gaps[k] != 13) begin n_bad++; $display("FAIL rr_gap[%0d]: got %0d want 13", k, gaps[k]); end
        end
    endtask

    task automatic test_timeout();
        int rd_c, to_c, to_at, regrant_at, pops_at_to, busy_low, rd2, to2;
        logic [N-1:0] regrant_val;
        do_reset();
        bus.req_i = 3'b100;
        rd_c = 0; to_c = 0; to_at = -1; regrant_at = -1; pops_at_to = 0; busy_low = 0;
        regrant_val = '0;
        for (int k = 0; k < 1600; k++) begin
            step();
            rd_c += int'(s_rd[2]);
            if (s_to) begin
                to_c++;
                if (to_at < 0) begin
                    to_at = k;
                    pops_at_to = rd_c;
                    pop_cnt[2] = 0;
                    frame_len[2] = 1518;
                end
            end
            if (to_at >= 0 && s_grant != '0) begin
                regrant_at = k;
                regrant_val = s_grant;
                break;
            end
            if (to_at >= 0 && !s_busy) busy_low++;
        end
        n_cmp++; if (pops_at_to != 1518) begin n_bad++; $display("FAIL wd_pops: got %0d want 1518", pops_at_to); end
        n_cmp++; if (to_c != 1) begin n_bad++; $display("FAIL wd_pulse_width: got %0d want 1", to_c); end
        n_cmp++; if (regrant_at - to_at != 13) begin n_bad++; $display("FAIL wd_regrant_delay: got %0d want 13", regrant_at - to_at); end
        n_cmp++; if (regrant_val !== 3'b100) begin n_bad++; $display("FAIL wd_regrant: got %b want 100", regrant_val); end
        n_cmp++; if (busy_low != 1) begin n_bad++; $display("FAIL wd_idle_cycles: got %0d want 1", busy_low); end
        // Second frame ends with eof exactly on the last allowed byte.
        bus.req_i = '0;
        rd2 = int'(s_rd[2]);
        to2 = 0;
        for (int k = 0; k < 1600; k++) begin
            step();
            rd2 += int'(s_rd[2]);
            to2 += int'(s_to);
            if (!s_busy) break;
        end
        n_cmp++; if (rd2 != 1518) begin n_bad++; $display("FAIL wd_edge_pops: got %0d want 1518", rd2); end
        n_cmp++; if (to2 != 0) begin n_bad++; $display("FAIL wd_edge_timeout: got %0d want 0", to2); end
    endtask

    task automatic test_grant_hold();
        int rd_c, tx_c, bad_own, grants;
        logic [N-1:0] prev_g;
        do_reset();
        frame_len[0] = 100;
        bus.req_i = 3'b001;
        rd_c = 0; tx_c = 0; bad_own = 0; grants = 0; prev_g = '0;
        for (int k = 0; k < 200; k++) begin
            eof_force = (k == 40) ? 3'b010 : 3'b000;
            step();
            rd_c += int'(s_rd[0]);
            tx_c += int'(s_tx);
            if (rd_c >= 10) bus.req_i = '0;
            if (s_rd != '0 && (s_grant !== 3'b001 || s_rd !== 3'b001)) bad_own++;
            if (s_grant != '0 && prev_g == '0) grants++;
            prev_g = s_grant;
        end
        eof_force = '0;
        n_cmp++; if (rd_c != 100) begin n_bad++; $display("FAIL hold_pops: got %0d want 100", rd_c); end
        n_cmp++; if (tx_c != 100) begin n_bad++; $display("FAIL hold_tx_cycles: got %0d want 100", tx_c); end
        n_cmp++; if (bad_own != 0) begin n_bad++; $display("FAIL hold_owner: got %0d bad cycles want 0", bad_own); end
        n_cmp++; if (grants != 1) begin n_bad++; $display("FAIL hold_grants: got %0d want 1", grants); end
    endtask

    task automatic test_reset_mid_frame();
        int rd_c;
        do_reset();
        frame_len[1] = 100;
        bus.req_i = 3'b010;
        rd_c = 0;
        for (int k = 0; k < 60; k++) begin
            step();
            rd_c += int'(s_rd[1]);
            if (rd_c == 30) break;
        end
        n_cmp++; if (rd_c != 30) begin n_bad++; $display("FAIL rstmid_setup: got %0d pops want 30", rd_c); end
        rst_i = 1'b1;
        step();
        n_cmp++; if (s_grant !== 3'b000) begin n_bad++; $display("FAIL rstmid_grant: got %b want 000", s_grant); end
        n_cmp++; if (s_rd !== 3'b000) begin n_bad++; $display("FAIL rstmid_rd_en: got %b want 000", s_rd); end
        n_cmp++; if (s_tx !== 1'b0) begin n_bad++; $display("FAIL rstmid_tx_ctrl: got %b want 0", s_tx); end
        n_cmp++; if (s_to !== 1'b0) begin n_bad++; $display("FAIL rstmid_timeout: got %b want 0", s_to); end
        rst_i = 1'b0;
        for (int i = 0; i < N; i++) begin
            pop_cnt[i] = 0;
            frame_len[i] = 64;
        end
        bus.req_i = 3'b111;
        step();
        n_cmp++; if (s_grant !== 3'b001) begin n_bad++; $display("FAIL rstmid_regrant: got %b want 001", s_grant); end
        bus.req_i = '0;
        for (int k = 0; k < 100; k++) step();
    endtask

    task automatic test_back_to_back();
        int gaps[$];
        int highs[$];
        int rd_total, tx_total, grants, low_run, hi_run;
        logic prev_tx, seen_rise;
        logic [N-1:0] prev_g;
        do_reset();
        frame_len[2] = 1;
        bus.req_i = 3'b100;
        rd_total = 0; tx_total = 0; grants = 0; low_run = 0; hi_run = 0;
        prev_tx = 1'b0; seen_rise = 1'b0; prev_g = '0;
        for (int k = 0; k < 90; k++) begin
            if (k == 60) bus.req_i = '0;
            step();
            rd_total += int'(s_rd[2]);
            tx_total += int'(s_tx);
            if (s_grant != '0 && prev_g == '0) grants++;
            prev_g = s_grant;
            if (s_tx && !prev_tx) begin
                if (seen_rise) gaps.push_back(low_run);
                seen_rise = 1'b1;
            end
            if (!s_tx && prev_tx) highs.push_back(hi_run);
            if (s_tx) begin hi_run++; low_run = 0; end
            else begin low_run++; hi_run = 0; end
            prev_tx = s_tx;
        end
        n_cmp++; if (gaps.size() < 3) begin n_bad++; $display("FAIL b2b_frames: got %0d gaps want >=3", gaps.size()); end
        foreach (gaps[k]) begin
            n_cmp++; if (gaps[k] != 13) begin n_bad++; $display("FAIL b2b_gap[%0d]: got %0d want 13", k, gaps[k]); end
        end
        foreach (highs[k]) begin
            n_cmp++; if (highs[k] != 1) begin n_bad++; $display("FAIL b2b_tx_width[%0d]: got %0d want 1", k, highs[k]); end
        end
        n_cmp++; if (rd_total != grants) begin n_bad++; $display("FAIL b2b_pops_per_frame: got %0d pops for %0d frames", rd_total, grants); end
        n_cmp++; if (tx_total != rd_total) begin n_bad++; $display("FAIL b2b_tx_vs_pops: got %0d tx want %0d", tx_total, rd_total); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench time limit");
    end

    initial begin
        test_reset();
        test_single_frame();
        test_round_robin();
        test_timeout();
        test_grant_hold();
        test_reset_mid_frame();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tx_port_scheduler.md
TX_PORT_SCHEDULER -- requirements
Module: tx_port_scheduler

Interface
REQ-001 SHALL have parameter P_NUM_REQ, default 3: number of RX virtual-queue requesters sharing one TX port.
REQ-002 SHALL have parameter P_IFG_CYCLES, default 12: inter-frame gap length in cycles (96 bit times at 8 bits/cycle).
REQ-003 SHALL have parameter P_MAX_BYTES, default 1518: maximum frame length before watchdog abort.
REQ-004 SHALL have port clk_i  input  1  the single clock; all logic is on the rising edge.
REQ-005 SHALL have port rst_i  input  1  synchronous, active-high reset.
REQ-006 SHALL have port req_i  input  P_NUM_REQ  bit i high when requester i holds at least one complete frame.
REQ-007 SHALL have port eof_i  input  P_NUM_REQ  bit i high when the byte popped from requester i this cycle is its last byte; valid only with rd_en_o[i].
REQ-008 SHALL have port rd_en_o  output  P_NUM_REQ  pops one byte from requester i; one-hot or zero.
REQ-009 SHALL have port grant_o  output  P_NUM_REQ  registered one-hot owner of the TX port; zero when unowned.
REQ-010 SHALL have port tx_ctrl_o  output  1  TX data-valid, rd_en_o OR-reduced and delayed one cycle (matches the queue's 1-cycle read latency).
REQ-011 SHALL have port busy_o  output  1  high in XFER or GAP state.
REQ-012 SHALL have port timeout_o  output  1  one-cycle pulse on watchdog abort.

Function
REQ-013 SHALL implement a registered FSM with states IDLE, XFER and GAP.
REQ-014 IDLE: if req_i != 0, SHALL select one requester round-robin, register grant_o, and go to XFER; otherwise SHALL stay in IDLE.
REQ-015 Round-robin: search SHALL start at index (ptr+1) mod P_NUM_REQ, ascending with wrap; ptr SHALL update to the granted index on each grant.
REQ-016 Latency: req_i seen in IDLE at cycle N SHALL give grant_o and rd_en_o high at N+1 and tx_ctrl_o high at N+2.
REQ-017 XFER: rd_en_o SHALL equal grant_o every cycle; grant SHALL hold regardless of req_i changes.
REQ-018 XFER: eof_i of the granted index with rd_en_o SHALL move to GAP next cycle, clear grant_o, and zero rd_en_o; eof_i of non-granted indices SHALL be ignored.
REQ-019 XFER SHALL count popped bytes in a counter of width clog2(P_MAX_BYTES+1), cleared on entry to XFER.
REQ-020 If the P_MAX_BYTES-th pop occurs without eof, the FSM SHALL go to GAP, clear grant_o, and pulse timeout_o for exactly the next cycle.
REQ-021 If eof and the P_MAX_BYTES-th pop coincide, this SHALL be a normal end: timeout_o stays low.
REQ-022 GAP SHALL last exactly P_IFG_CYCLES cycles via a down-counter, ignore req_i, then go to IDLE.
REQ-023 The minimum tx_ctrl_o low time between consecutive frames SHALL be P_IFG_CYCLES+1 cycles.
REQ-024 A 1-byte frame (eof on the first pop) SHALL give one rd_en_o cycle and one tx_ctrl_o cycle.
REQ-025 busy_o SHALL be registered-state-derived, with no combinational path from req_i.

Reset
REQ-026 While rst_i is high at a clock edge, the FSM SHALL go to IDLE and SHALL set grant_o=0, rd_en_o=0, tx_ctrl_o=0, busy_o=0, timeout_o=0, counters=0 and ptr=P_NUM_REQ-1, so index 0 wins first.
REQ-027 Reset mid-frame SHALL abort immediately, with no timeout_o pulse and no further pops.

Verification
REQ-028 req_i=3'b010, 64-byte frame with eof on pop 64 -> grant_o=3'b010 one cycle later; rd_en_o[1] high 64 cycles; tx_ctrl_o high 64 cycles, lagging 1; busy_o high 64+12 cycles.
REQ-029 req_i=3'b111 held, all frames 64 bytes -> grant order 0,1,2,0,1; tx_ctrl_o low exactly 13 cycles between frames.
REQ-030 req_i=3'b100 with eof never asserted -> 1518 pops, timeout_o high 1 cycle, 12-cycle GAP, then re-grant to 2 if still requesting.
REQ-031 req_i[0] dropped after byte 10 of a 100-byte frame -> rd_en_o[0] continues to eof at byte 100; eof_i[1] pulsed mid-frame is ignored.
REQ-032 rst_i pulsed at byte 30 of a frame on index 1 -> next cycle grant_o=0, rd_en_o=0, tx_ctrl_o=0; after release with req_i=3'b111 -> grant_o=3'b001.
REQ-033 Single-byte frames on index 2 back-to-back -> each frame gives 1 tx_ctrl_o cycle, separated by 13 low cycles.
